nn_layer_serializer: RTL and testbench
======================================

# nn_layer_serializer

Consumer end of a neuron layer's parallel output. It captures the layer's `NUM_NEURONS` result words when the layer signals all-neurons-valid, then streams them one word per beat over a valid/ready interface. That stream feeds the next layer's serial `in` port, or the test harness. While streaming, it also computes the signed argmax of the frame, so the final layer yields a class index directly.

## Interface
- `NUM_NEURONS`, 10, words per frame; must be ≥ 2.
- `data_width`, 16, word width; words are two's-complement fixed-point.
- `IDX_W`, `$clog2(NUM_NEURONS)`, index width (derived, not overridden).

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  layer all-valid level (layer `valid_out`).
- `in_data`  in  `NUM_NEURONS`×`data_width`  layer outputs; element `i` is neuron `i`.
- `out_data`  out  `data_width`  current beat word.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts beat.
- `out_last`  out  1  high with the beat carrying word `NUM_NEURONS-1`.
- `out_idx`  out  `IDX_W`  neuron index of current beat.
- `busy`  out  1  frame held, not fully sent.
- `overrun`  out  1  one-cycle pulse: frame start detected while busy and not finishing; that frame is discarded.
- `class_idx`  out  `IDX_W`  argmax index of the last completed frame; held until the next frame completes.
- `class_valid`  out  1  one-cycle pulse when `class_idx` updates.

## Operation
- Start detection: `in_valid_d` registers `in_valid`. A start occurs when `in_valid`=1 and `in_valid_d`=0 (rising edge), because the layer holds valid as a level.
- The FSM has two states, IDLE and SEND.
  - IDLE→SEND on a start: latch all of `in_data` into the frame buffer, set `cnt`=0, and clear the argmax trackers.
  - SEND: `out_valid`=1. `out_data`=`buf[cnt]`. `out_idx`=`cnt`. `out_last`=(`cnt`==`NUM_NEURONS-1`).
  - Handshake (`out_valid`&&`out_ready` at an edge) on a non-last beat: `cnt`+1.
  - Handshake on the last beat: go to IDLE, unless a start occurs on the same edge. In that case, capture the new frame and stay in SEND with `cnt`=0 (zero-bubble).
- A start in SEND without a last-beat handshake on that edge pulses `overrun` for one cycle. The buffer, `cnt` and trackers are unchanged, and the new frame is lost.
- `buf` and `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- Argmax:
  - On each handshake, compare the word signed against `max_val`. Beat 0 always loads. Later beats load only on strictly greater, so ties keep the lowest index.
  - On the last-beat handshake, the final index (including that beat) is registered into `class_idx`, and `class_valid` pulses.
- `busy` = (state==SEND).

## Timing
- Reset: state IDLE; `cnt`, `in_valid_d`, the buffer and the trackers are 0. All outputs are 0: `out_data`, `out_valid`, `out_last`, `out_idx`, `busy`, `overrun`, `class_idx`, `class_valid`.
- If `in_valid` is already 1 at reset release, the first edge sees `in_valid_d`=0, so that counts as a start.
- Latency: for a start sampled at edge N, `out_valid`=1 and word 0 appear after edge N.
- With `out_ready` held at 1, a frame takes exactly `NUM_NEURONS` cycles.
- `class_valid` and the new `class_idx` appear after the edge of the last handshake, and `class_valid` drops after the next edge.
- `overrun` is registered: it is high for the cycle following the offending edge.
- Asserting `rst` mid-frame drops the frame immediately, with no `class_valid` and no `overrun`.

## Test plan
- Basic frame, `out_ready`=1: `in_data`={0..9}=0x0010,0x0020,…,0x00A0, `in_valid` rises → 10 consecutive beats 0x0010…0x00A0, `out_last` only on beat 9, then `class_idx`=9 with a one-cycle `class_valid`.
- Backpressure: same frame, `out_ready` toggled 1,0,0,1,… → every word delivered once in order; `out_data` stable during stalls; total beats = 10.
- Signed/tie argmax: words = -5,3,0x7FFF,-32768,0x7FFF,0,… → `class_idx`=2; all words 0xFFFF → `class_idx`=0.
- Overrun: second `in_valid` rising edge at beat 4 of a frame → `overrun` pulses once; the original 10 words complete unchanged; no second frame is streamed.
- Back-to-back: a new rising edge on the same edge as the beat-9 handshake → beat 0 of the new frame follows the next cycle; `busy` stays 1; no `overrun`.
- Reset mid-frame: `rst` asserted after beat 3 → all outputs 0 on assertion; after release with `in_valid`=0, the block stays idle until the next rising edge.

Source files
------------

// File: rtl/nn_layer_serializer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : nn_layer_serializer_if
//  Brief    : Valid/ready word stream carrying one neuron result per beat.
//  Revision : 1.0 - initial release
// ============================================================================
interface nn_layer_serializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 4
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IDX_W-1:0]      out_idx;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_idx,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/nn_layer_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : nn_layer_serializer
//  Brief    : Captures a layer's parallel outputs, streams them one word per
//             beat and reports the signed argmax of each completed frame.
//  Revision : 1.0 - initial release
// ============================================================================
module nn_layer_serializer #(
    parameter  int NUM_NEURONS = 10,
    parameter  int DATA_WIDTH  = 16,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst,
    input  wire logic                                   in_valid,
    input  wire logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] in_data,
    nn_layer_serializer_if.master                       out_if,
    output logic                                        busy,
    output logic                                        overrun,
    output logic [IDX_W-1:0]                            class_idx,
    output logic                                        class_valid
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       cnt_q, cnt_d;
    logic                                   in_valid_d_q;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0]                  max_val_q, max_val_d;
    logic [IDX_W-1:0]                       max_idx_q, max_idx_d;
    logic [IDX_W-1:0]                       class_idx_q, class_idx_d;
    logic                                   class_valid_q, class_valid_d;
    logic                                   overrun_q, overrun_d;

    logic                  w_start;
    logic                  w_send;
    logic                  w_hs;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_beat;
    logic                  w_take;
    logic [IDX_W-1:0]      w_best_idx;

    // The layer holds valid as a level, so only its rising edge opens a frame.
    assign w_start    = in_valid && !in_valid_d_q;
    assign w_send     = (state_q == SEND);
    assign w_hs       = w_send && out_if.out_ready;
    assign w_last     = (cnt_q == c_last_idx);
    assign w_beat     = frame_q[cnt_q];
    assign w_take     = (cnt_q == '0) || ($signed(w_beat) > $signed(max_val_q));
    assign w_best_idx = w_take ? cnt_q : max_idx_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
        class_idx_d   = class_idx_q;
        class_valid_d = 1'b0;
        overrun_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d   = SEND;
                    frame_d   = in_data;
                    cnt_d     = '0;
                    max_val_d = '0;
                    max_idx_d = '0;
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (w_take) begin
                        max_val_d = w_beat;
                        max_idx_d = cnt_q;
                    end
                    if (w_last) begin
                        class_idx_d   = w_best_idx;
                        class_valid_d = 1'b1;
                        if (w_start) begin
                            // Zero-bubble: next frame's beat 0 follows directly.
                            frame_d   = in_data;
                            cnt_d     = '0;
                            max_val_d = '0;
                            max_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d     = cnt_q + IDX_W'(1);
                        overrun_d = w_start;
                    end
                end else begin
                    overrun_d = w_start;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            in_valid_d_q  <= 1'b0;
            frame_q       <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            in_valid_d_q  <= in_valid;
            frame_q       <= frame_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Stream outputs read as zero whenever no frame is held.
    assign out_if.out_valid = w_send;
    assign out_if.out_data  = w_send ? w_beat : '0;
    assign out_if.out_idx   = w_send ? cnt_q : '0;
    assign out_if.out_last  = w_send && w_last;

    assign busy        = w_send;
    assign overrun     = overrun_q;
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_nn_layer_serializer
//  Brief    : Directed self-checking bench for nn_layer_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nn_layer_serializer;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [N-1:0][DW-1:0]  in_data;
    logic                  busy;
    logic                  overrun;
    logic [IW-1:0]         class_idx;
    logic                  class_valid;

    logic [N-1:0][DW-1:0]  frame_a, frame_s, frame_f;
    int                    errors;
    int                    checks;
    int                    got;
    logic                  hs;

    nn_layer_serializer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) s_if ();

    nn_layer_serializer #(
        .NUM_NEURONS (N),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_if      (s_if),
        .busy        (busy),
        .overrun     (overrun),
        .class_idx   (class_idx),
        .class_valid (class_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Opens a frame with out_ready high and drains all beats; ends just after
    // the last handshake edge.
    task automatic play_frame(input logic [N-1:0][DW-1:0] f);
        in_valid = 1'b0;
        step();
        in_data         = f;
        s_if.out_ready  = 1'b1;
        in_valid        = 1'b1;
        step();
        chk("play_first_valid", 32'(s_if.out_valid), 32'd1);
        for (int k = 0; k < N; k++) step();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        s_if.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            frame_a[i] = 16'((i + 1) * 16);
            frame_f[i] = 16'hFFFF;
            frame_s[i] = 16'h0000;
        end
        frame_s[0] = 16'hFFFB;
        frame_s[1] = 16'h0003;
        frame_s[2] = 16'h7FFF;
        frame_s[3] = 16'h8000;
        frame_s[4] = 16'h7FFF;

        // Reset state
        step();
        step();
        chk("rst_out_valid",   32'(s_if.out_valid), 32'd0);
        chk("rst_out_data",    32'(s_if.out_data),  32'd0);
        chk("rst_out_last",    32'(s_if.out_last),  32'd0);
        chk("rst_out_idx",     32'(s_if.out_idx),   32'd0);
        chk("rst_busy",        32'(busy),           32'd0);
        chk("rst_overrun",     32'(overrun),        32'd0);
        chk("rst_class_idx",   32'(class_idx),      32'd0);
        chk("rst_class_valid", 32'(class_valid),    32'd0);
        rst = 1'b0;
        step();
        chk("idle_out_valid", 32'(s_if.out_valid), 32'd0);

        // Basic frame, out_ready held high
        in_data        = frame_a;
        s_if.out_ready = 1'b1;
        in_valid       = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            chk("basic_valid", 32'(s_if.out_valid), 32'd1);
            chk("basic_data",  32'(s_if.out_data),  32'(frame_a[i]));
            chk("basic_idx",   32'(s_if.out_idx),   32'(i));
            chk("basic_last",  32'(s_if.out_last),  32'(i == N - 1));
            chk("basic_cv_low", 32'(class_valid),   32'd0);
            step();
        end
        chk("basic_class_valid", 32'(class_valid),    32'd1);
        chk("basic_class_idx",   32'(class_idx),      32'd9);
        chk("basic_done_valid",  32'(s_if.out_valid), 32'd0);
        chk("basic_done_busy",   32'(busy),           32'd0);
        step();
        chk("basic_cv_drop",     32'(class_valid),    32'd0);
        chk("basic_class_held",  32'(class_idx),      32'd9);

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        got = 0;
        for (int cyc = 0; cyc < 60 && got < N; cyc++) begin
            s_if.out_ready = (cyc % 3 == 0);
            chk("bp_valid", 32'(s_if.out_valid), 32'd1);
            chk("bp_data",  32'(s_if.out_data),  32'(frame_a[got]));
            chk("bp_idx",   32'(s_if.out_idx),   32'(got));
            hs = s_if.out_ready;
            step();
            if (hs) got++;
        end
        chk("bp_beats",       32'(got),            32'd10);
        chk("bp_class_valid", 32'(class_valid),    32'd1);
        chk("bp_class_idx",   32'(class_idx),      32'd9);
        chk("bp_done_valid",  32'(s_if.out_valid), 32'd0);

        // Signed argmax and ties
        play_frame(frame_s);
        chk("signed_class_valid", 32'(class_valid), 32'd1);
        chk("signed_class_idx",   32'(class_idx),   32'd2);
        play_frame(frame_f);
        chk("tie_class_valid",    32'(class_valid), 32'd1);
        chk("tie_class_idx",      32'(class_idx),   32'd0);

        // Overrun: new rising edge while beat 4 is handshaken
        in_valid = 1'b0;
        step();
        in_data  = frame_a;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("ovr_pre_idx", 32'(s_if.out_idx), 32'd4);
        in_data  = frame_f;
        in_valid = 1'b1;
        step();
        chk("ovr_pulse", 32'(overrun),        32'd1);
        chk("ovr_data5", 32'(s_if.out_data), 32'(frame_a[5]));
        chk("ovr_idx5",  32'(s_if.out_idx),  32'd5);
        chk("ovr_busy",  32'(busy),          32'd1);
        for (int i = 6; i < N; i++) begin
            step();
            chk("ovr_pulse_low", 32'(overrun),        32'd0);
            chk("ovr_data",      32'(s_if.out_data), 32'(frame_a[i]));
        end
        step();
        chk("ovr_class_valid", 32'(class_valid),    32'd1);
        chk("ovr_class_idx",   32'(class_idx),      32'd9);
        chk("ovr_end_overrun", 32'(overrun),        32'd0);
        chk("ovr_done_valid",  32'(s_if.out_valid), 32'd0);
        step();
        step();
        chk("ovr_no_second",   32'(s_if.out_valid), 32'd0);

        // Back-to-back: new rising edge on the beat-9 handshake edge
        in_valid = 1'b0;
        step();
        in_data  = frame_a;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b0;
        step();
        chk("b2b_last_beat", 32'(s_if.out_last), 32'd1);
        in_data  = frame_s;
        in_valid = 1'b1;
        step();
        chk("b2b_busy",        32'(busy),            32'd1);
        chk("b2b_valid",       32'(s_if.out_valid),  32'd1);
        chk("b2b_data0",       32'(s_if.out_data),   32'(frame_s[0]));
        chk("b2b_idx0",        32'(s_if.out_idx),    32'd0);
        chk("b2b_no_overrun",  32'(overrun),         32'd0);
        chk("b2b_class_valid", 32'(class_valid),     32'd1);
        chk("b2b_class_idx",   32'(class_idx),       32'd9);
        step();
        chk("b2b_data1",       32'(s_if.out_data),   32'(frame_s[1]));
        chk("b2b_overrun_low", 32'(overrun),         32'd0);
        chk("b2b_cv_drop",     32'(class_valid),     32'd0);
        for (int i = 0; i < N - 1; i++) step();
        chk("b2b2_class_valid", 32'(class_valid),    32'd1);
        chk("b2b2_class_idx",   32'(class_idx),      32'd2);
        chk("b2b2_busy",        32'(busy),           32'd0);

        // Reset asserted mid-frame
        in_valid = 1'b0;
        step();
        in_data  = frame_a;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("mid_pre_idx", 32'(s_if.out_idx), 32'd4);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_out_valid",   32'(s_if.out_valid), 32'd0);
        chk("mid_out_data",    32'(s_if.out_data),  32'd0);
        chk("mid_out_last",    32'(s_if.out_last),  32'd0);
        chk("mid_out_idx",     32'(s_if.out_idx),   32'd0);
        chk("mid_busy",        32'(busy),           32'd0);
        chk("mid_overrun",     32'(overrun),        32'd0);
        chk("mid_class_idx",   32'(class_idx),      32'd0);
        chk("mid_class_valid", 32'(class_valid),    32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_idle_valid", 32'(s_if.out_valid), 32'd0);
        chk("post_rst_idle_busy",  32'(busy),           32'd0);
        chk("post_rst_no_cv",      32'(class_valid),    32'd0);
        in_valid = 1'b1;
        step();
        chk("post_rst_valid", 32'(s_if.out_valid), 32'd1);
        chk("post_rst_data0", 32'(s_if.out_data),  32'(frame_a[0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
